// File: rtl/alu_arbiter.sv
// Two requesters share one ALU: arbitrate in IDLE, compute in EXEC, hold the response in RESP.
// EXE_CMD: MOV=1 MVN=9 ADD=2 ADC=3 SUB=4 SBC=5 AND=6 ORR=7 EOR=8; any other code yields 0.

module alu_arbiter_alu #(
  localparam int unsigned DATA_W = 32,
  localparam int unsigned CMD_W  = 4,
  localparam int unsigned SR_W   = 4
) (
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result_c,
  output logic [SR_W-1:0]   sr_c
);
  localparam int unsigned WIDE_W = DATA_W + 1;
  localparam int unsigned MSB    = DATA_W - 1;

  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;

  logic [WIDE_W-1:0] wide;
  logic              carry;
  logic              ovf;

  // Subtraction carry is the borrow out of the 33-bit difference.
  always_comb begin
    wide     = '0;
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (cmd)
      CMD_MOV: result_c = val2;
      CMD_MVN: result_c = ~val2;
      CMD_ADD, CMD_ADC: begin
        wide     = {1'b0, val1} + {1'b0, val2} + WIDE_W'(cmd == CMD_ADC && carry_in);
        result_c = wide[MSB:0];
        carry    = wide[DATA_W];
        ovf      = (val1[MSB] == val2[MSB]) && (result_c[MSB] != val1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        wide     = {1'b0, val1} - {1'b0, val2} - WIDE_W'(cmd == CMD_SBC && !carry_in);
        result_c = wide[MSB:0];
        carry    = wide[DATA_W];
        ovf      = (val1[MSB] != val2[MSB]) && (result_c[MSB] != val1[MSB]);
      end
      CMD_AND: result_c = val1 & val2;
      CMD_ORR: result_c = val1 | val2;
      CMD_EOR: result_c = val1 ^ val2;
      default: ;
    endcase
    sr_c = {result_c == '0, carry, result_c[MSB], ovf};
  end
endmodule

module alu_arbiter #(
  parameter bit FAIR = 1'b1,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned CMD_W  = 4,
  localparam int unsigned SR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic [DATA_W-1:0] req0_val1,
  input  logic [DATA_W-1:0] req0_val2,
  input  logic              req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic [DATA_W-1:0] req1_val1,
  input  logic [DATA_W-1:0] req1_val2,
  input  logic              req1_s,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic [SR_W-1:0]   resp_sr,
  output logic [SR_W-1:0]   status_reg
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic              s;
  } op_t;

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  op_t               op_sel_c;
  logic              grant;
  logic              last_grant;
  logic [DATA_W-1:0] alu_result_c;
  logic [SR_W-1:0]   alu_sr_c;

  // A lone requester always wins; a tie goes round-robin or to req0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = FAIR ? ~last_grant : 1'b0;
    else if (req1_valid)          grant = 1'b1;
    op_sel_c = grant ? {req1_cmd, req1_val1, req1_val2, req1_s}
                     : {req0_cmd, req0_val1, req0_val2, req0_s};
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_next = EXEC;
          req0_ready = rst && !grant;
          req1_ready = rst && grant;
        end
      end
      EXEC: state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  alu_arbiter_alu u_alu (
    .cmd      (op_q.cmd),
    .val1     (op_q.val1),
    .val2     (op_q.val2),
    .carry_in (status_reg[2]),
    .result_c (alu_result_c),
    .sr_c     (alu_sr_c)
  );

  // Operands captured on accept; results and flags captured at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q        <= '0;
      last_grant  <= 1'b1;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_sr     <= '0;
      status_reg  <= '0;
    end else begin
      if (req0_ready || req1_ready) begin
        op_q       <= op_sel_c;
        resp_id    <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        resp_valid  <= 1'b1;
        resp_result <= alu_result_c;
        resp_sr     <= alu_sr_c;
        if (op_q.s) status_reg <= alu_sr_c;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011, SUB = 4'b0100;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_cmd [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [1:0]  req_s;
  logic        resp_ready;

  logic        ready0, ready1, resp_valid, resp_id;
  logic [31:0] resp_result;
  logic [3:0]  resp_sr, status_reg;
  logic        fp_ready0, fp_ready1, fp_resp_valid, fp_resp_id;
  logic [31:0] fp_resp_result;
  logic [3:0]  fp_resp_sr, fp_status;

  int errors = 0;
  int checks = 0;

  // Model state
  int          m_phase;
  bit          m_last;
  logic [3:0]  m_status;
  logic [31:0] e_res;
  logic [3:0]  e_sr, e_status;
  bit          e_id;
  bit          hold_valid;

  // Last sampled values
  bit          obs_r0, obs_r1, obs_valid, obs_id, obs_fp_valid, obs_fp_id, obs_fp_r1;
  logic [31:0] obs_result;
  logic [3:0]  obs_sr, obs_status;

  alu_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(ready0), .req0_cmd(req_cmd[0]),
    .req0_val1(req_a[0]), .req0_val2(req_b[0]), .req0_s(req_s[0]),
    .req1_valid(req_valid[1]), .req1_ready(ready1), .req1_cmd(req_cmd[1]),
    .req1_val1(req_a[1]), .req1_val2(req_b[1]), .req1_s(req_s[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_sr(resp_sr), .status_reg(status_reg)
  );

  alu_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(fp_ready0), .req0_cmd(req_cmd[0]),
    .req0_val1(req_a[0]), .req0_val2(req_b[0]), .req0_s(req_s[0]),
    .req1_valid(req_valid[1]), .req1_ready(fp_ready1), .req1_cmd(req_cmd[1]),
    .req1_val1(req_a[1]), .req1_val2(req_b[1]), .req1_s(req_s[1]),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_result(fp_resp_result), .resp_sr(fp_resp_sr), .status_reg(fp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural ALU behaviour from signed/unsigned integer arithmetic.
  function automatic logic [35:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    longint unsigned ua, ub, x, ures;
    longint sa, sb, sres;
    logic [31:0] r;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        x    = (cmd == ADC) ? longint'(cin) : 0;
        ures = ua + ub + x;
        r    = ures[31:0];
        c    = ures > 64'hFFFF_FFFF;
        sres = sa + sb + longint'(x);
        v    = sres > SMAX || sres < SMIN;
      end
      4'b0100, 4'b0101: begin
        x    = (cmd == 4'b0101) ? longint'(!cin) : 0;
        ures = ua - ub - x;
        r    = ures[31:0];
        c    = ua < ub + x;
        sres = sa - sb - longint'(x);
        v    = sres > SMAX || sres < SMIN;
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: ;
    endcase
    return {r, r == 32'd0, c, r[31], v};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_req(input int id, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    req_valid[id] = 1'b1; req_cmd[id] = cmd; req_a[id] = a; req_b[id] = b; req_s[id] = s;
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step();
    bit g, e0, e1;
    int sel;
    logic [35:0] rr;
    #1;
    g = 1'b0; e0 = 1'b0; e1 = 1'b0;
    if (rst && m_phase == 0 && req_valid != 2'b00) begin
      g  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      e0 = ~g; e1 = g;
    end
    obs_r0 = ready0; obs_r1 = ready1; obs_valid = resp_valid; obs_id = resp_id;
    obs_result = resp_result; obs_sr = resp_sr; obs_status = status_reg;
    obs_fp_valid = fp_resp_valid; obs_fp_id = fp_resp_id; obs_fp_r1 = fp_ready1;
    check("req0_ready", 64'(ready0), 64'(e0));
    check("req1_ready", 64'(ready1), 64'(e1));
    check("resp_valid", 64'(resp_valid), 64'(m_phase == 2));
    check("status_reg", 64'(status_reg), 64'(m_status));
    if (m_phase == 2) begin
      check("resp_result", 64'(resp_result), 64'(e_res));
      check("resp_sr", 64'(resp_sr), 64'(e_sr));
      check("resp_id", 64'(resp_id), 64'(e_id));
    end
    if (!rst) begin
      m_phase = 0; m_last = 1'b1; m_status = 4'b0000;
    end else if (e0 || e1) begin
      sel      = int'(g);
      rr       = ref_alu(req_cmd[sel], req_a[sel], req_b[sel], m_status[2]);
      e_res    = rr[35:4];
      e_sr     = rr[3:0];
      e_id     = g;
      e_status = req_s[sel] ? rr[3:0] : m_status;
      m_last   = g;
      m_phase  = 1;
    end else if (m_phase == 1) begin
      m_phase  = 2;
      m_status = e_status;
    end else if (m_phase == 2 && resp_ready) begin
      m_phase = 0;
    end
    @(posedge clk);
    #1;
    if (!hold_valid) begin
      if (e0) req_valid[0] = 1'b0;
      if (e1) req_valid[1] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    step();
    check("rst_resp_valid", 64'(obs_valid), 64'd0);
    check("rst_resp_result", 64'(obs_result), 64'd0);
    check("rst_resp_sr", 64'(obs_sr), 64'd0);
    check("rst_resp_id", 64'(obs_id), 64'd0);
    check("rst_status", 64'(obs_status), 64'd0);
    rst = 1'b1;
  endtask

  task automatic do_op(input int id, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic [31:0] x_res,
                       input logic [3:0] x_sr, input logic [3:0] x_status);
    int t_acc, t_resp;
    t_acc = -1; t_resp = -1;
    resp_ready = 1'b1;
    set_req(id, cmd, a, b, s);
    for (int n = 0; n < 10 && t_resp < 0; n++) begin
      step();
      if (t_acc < 0 && ((id == 1) ? obs_r1 : obs_r0)) t_acc = n;
      if (obs_valid) begin
        t_resp = n;
        check("op_result", 64'(obs_result), 64'(x_res));
        check("op_sr", 64'(obs_sr), 64'(x_sr));
        check("op_id", 64'(obs_id), 64'(id));
        check("op_status", 64'(obs_status), 64'(x_status));
      end
    end
    check("op_latency", 64'(t_resp - t_acc), 64'd2);
  endtask

  initial begin
    int t0, t1, fp_count;
    logic [31:0] cap_res;
    logic [3:0]  cap_sr;
    bit          cap_id;
    rst = 1'b0; req_valid = 2'b00; resp_ready = 1'b1; req_s = 2'b00; hold_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin req_cmd[i] = '0; req_a[i] = '0; req_b[i] = '0; end
    m_phase = 0; m_last = 1'b1; m_status = 4'b0000;
    e_res = '0; e_sr = '0; e_status = '0; e_id = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Signed overflow into the sign bit, then the carry chain through status C
    do_op(0, ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b0011, 4'b0011);
    do_op(0, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b1100, 4'b1100);
    do_op(1, ADC, 32'd1, 32'd1, 1'b0, 32'd3, 4'b0000, 4'b1100);
    do_op(0, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'd0, 4'b1000, 4'b1000);

    // Simultaneous request right after reset
    do_reset();
    t0 = -1; t1 = -1;
    set_req(0, MOV, 32'd0, 32'hA5A5_0000, 1'b0);
    set_req(1, MOV, 32'd0, 32'h0000_5A5A, 1'b0);
    for (int n = 0; n < 8; n++) begin
      step();
      if (obs_r0 && t0 < 0) t0 = n;
      if (obs_r1 && t1 < 0) t1 = n;
    end
    check("sim_req0_first", 64'(t0), 64'd0);
    check("sim_ready_gap", 64'(t1 - t0), 64'd3);

    // Backpressure with both requesters waiting
    resp_ready = 1'b0;
    set_req(0, SUB, 32'd10, 32'd3, 1'b0);
    set_req(1, ADD, 32'd4, 32'd5, 1'b0);
    for (int n = 0; n < 5 && !obs_valid; n++) step();
    check("bp_resp_seen", 64'(obs_valid), 64'd1);
    cap_res = obs_result; cap_sr = obs_sr; cap_id = obs_id;
    for (int n = 0; n < 5; n++) begin
      step();
      check("bp_stable", {obs_result, 28'd0, obs_sr, 3'd0, obs_id}, {cap_res, 28'd0, cap_sr, 3'd0, cap_id});
      check("bp_no_ready", 64'({obs_r1, obs_r0}), 64'd0);
    end
    resp_ready = 1'b1;
    repeat (8) step();

    // Reset while a flag-updating SUB is in EXEC
    set_req(0, SUB, 32'd3, 32'd5, 1'b1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      check("midrst_no_resp", 64'(obs_valid), 64'd0);
      check("midrst_status", 64'(obs_status), 64'd0);
    end

    // Fixed priority instance under continuous contention
    do_reset();
    hold_valid = 1'b1;
    set_req(0, MOV, 32'd0, 32'd11, 1'b0);
    set_req(1, MOV, 32'd0, 32'd22, 1'b0);
    fp_count = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      check("fp_no_ready1", 64'(obs_fp_r1), 64'd0);
      if (obs_fp_valid) begin
        fp_count++;
        check("fp_resp_id", 64'(obs_fp_id), 64'd0);
      end
    end
    check("fp_count", 64'(fp_count), 64'd4);
    hold_valid = 1'b0;
    req_valid = 2'b00;
    repeat (4) step();

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 4'($urandom_range(0, 15)), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR, 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  operation from requester N accepted this cycle.
REQ-007 req0_cmd / req1_cmd  input  4  EXE_CMD opcode, using the team's execute-command encoding.
REQ-008 req0_val1, req0_val2 / req1_val1, req1_val2  input  32  operands.
REQ-009 req0_s / req1_s  input  1  update the status register with this operation's flags.
REQ-010 resp_valid  output  1  response held for the consumer.
REQ-011 resp_ready  input  1  consumer takes the response.
REQ-012 resp_id  output  1  index of the requester being answered.
REQ-013 resp_result  output  32  ALU result.
REQ-014 resp_sr  output  4  ALU flags {Z,C,N,V}.
REQ-015 status_reg  output  4  architectural flags {Z,C,N,V}.

Function
REQ-016 The block SHALL contain exactly one ALU instance, shared by both requesters.
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 IDLE SHALL move to EXEC on the first cycle in which any reqN_valid is 1.
REQ-019 On that cycle the block SHALL assert ready for the granted requester only and latch its cmd, val1, val2, s and id.
REQ-020 reqN_ready SHALL be combinational and equal to (state==IDLE && reqN_valid && grant==N); it SHALL be 0 in every other state.
REQ-021 With FAIR=1 and both valid, the grant SHALL go to the requester not granted last; last_grant resets to 1, so req0 wins first.
REQ-022 With a single requester valid, that requester SHALL be granted regardless of last_grant.
REQ-023 With FAIR=0, req0 SHALL always win a tie.
REQ-024 In EXEC the ALU SHALL be driven from the latched operands, with its carry input taken from status_reg[2] (C).
REQ-025 At the end of EXEC the block SHALL register the ALU result and SR into resp_result and resp_sr.
REQ-026 If the latched s is 1, status_reg SHALL be loaded with the ALU SR in the same edge; otherwise it SHALL hold.
REQ-027 The FSM SHALL then enter RESP.
REQ-028 In RESP, resp_valid SHALL be 1 and resp_result, resp_sr and resp_id SHALL stay stable until resp_ready is 1; that edge returns the FSM to IDLE.
REQ-029 Latency: accept at edge N, resp_valid high after edge N+2; minimum 3 cycles per operation; no new accept while in EXEC or RESP.
REQ-030 Undefined opcodes SHALL pass through the ALU unchanged (result 0, SR 4'b1000); status_reg updates if s=1.
REQ-031 A requester SHALL hold its valid and operands while valid && !ready; the arbiter does not rely on operands after the accept cycle.

Reset
REQ-032 With rst=0 at a clock edge, regardless of state, the block SHALL go to IDLE with resp_valid=0, resp_result=0, resp_sr=0, resp_id=0, status_reg=4'b0000 and last_grant=1.
REQ-033 During reset both reqN_ready outputs SHALL be 0.
REQ-034 An in-flight operation SHALL be discarded with no response, and status_reg SHALL be left at reset value.

Verification
REQ-035 ADD scenario:
- stimulus: req0 ADD, val1=0x7FFFFFFF, val2=0x00000001, s=1;
- required: resp_valid 2 cycles after accept, resp_result=0x80000000, resp_sr=4'b0011, status_reg=4'b0011, resp_id=0.
REQ-036 Simultaneous-request scenario:
- stimulus: req0 and req1 valid together after reset, resp_ready=1;
- required: req0 is served first, then req1; the two ready pulses are 3 cycles apart.
REQ-037 Carry-chain scenario:
- stimulus: ADD 0xFFFFFFFF+0x1 with s=1, then ADC 1+1 with s=0;
- required: first response is result 0, SR 4'b1100; second response is result 3; status_reg stays 4'b1100.
REQ-038 Backpressure scenario:
- stimulus: resp_ready held 0 for 5 cycles while both requesters are valid;
- required: the response is stable for the whole window and no reqN_ready is asserted.
REQ-039 Mid-operation reset scenario:
- stimulus: rst=0 during EXEC of a SUB with s=1;
- required: resp_valid is never asserted and status_reg=0.
REQ-040 Fixed-priority scenario:
- stimulus: FAIR=0, both requesters continuously valid for 4 operations;
- required: resp_id is 0 for all four.
